// File: rtl/mux_n_1_reg.sv
// N:1 valid/ready multiplexer with a single registered output stage; fixed or round-robin select.
// Optional MUX_XFER_CNT_EN adds a 16-bit count of accepted input transfers on xfer_cnt.
module mux_n_1_reg #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      mode,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_ch,
    output logic                      out_valid,
`ifdef MUX_XFER_CNT_EN
    output logic [15:0]               xfer_cnt,
`endif
    input  logic                      out_ready
);

    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [SEL_W-1:0]    out_ch_q, out_ch_d;
    logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;

    logic                can_load, grant, tgt_ok, xfer;
    logic [SEL_W-1:0]    g;
    logic [CHANNELS-1:0] rot;
    int                  idx;

    assign can_load = !out_valid_q || out_ready;
    assign xfer     = grant && can_load;

    // Grant selection. In fixed mode the selected channel is offered ready even
    // when it is not valid; in round-robin only the winning valid channel is.
    always_comb begin
        grant  = 1'b0;
        tgt_ok = 1'b0;
        g      = '0;
        idx    = 0;
        rot    = CHANNELS'({in_valid, in_valid} >> rr_ptr_q);
        if (!mode) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (SEL_W'(k) == sel) begin
                    tgt_ok = 1'b1;
                    grant  = in_valid[k];
                    g      = sel;
                end
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (!grant && rot[k]) begin
                    grant = 1'b1;
                    idx   = int'(rr_ptr_q) + k;
                    if (idx >= CHANNELS) idx = idx - CHANNELS;
                    g     = SEL_W'(idx);
                end
            end
            tgt_ok = grant;
        end
    end

    always_comb begin
        for (int k = 0; k < CHANNELS; k++)
            in_ready[k] = !rst && tgt_ok && can_load && (g == SEL_W'(k));
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (can_load) out_valid_d = grant;
        if (xfer) begin
            out_data_d = in_data[int'(g)*WIDTH +: WIDTH];
            out_ch_d   = g;
            if (mode) rr_ptr_d = (int'(g) == CHANNELS-1) ? '0 : g + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

`ifdef MUX_XFER_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    assign cnt_d = xfer ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mux_n_1_reg.sv
// Directed bench for mux_n_1_reg: a 4-channel instance plus a 3-channel one for
// out-of-range select and non-power-of-two pointer wrap.
module tb_mux_n_1_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid, in_ready;
    logic [1:0]  sel, out_ch;
    logic        mode, out_valid, out_ready;
    logic [7:0]  out_data;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3, in_ready3;
    logic [1:0]  sel3, out_ch3;
    logic        mode3, out_valid3;
    logic [7:0]  out_data3;
`ifdef MUX_XFER_CNT_EN
    logic [15:0] xfer_cnt, xfer_cnt3;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mux_n_1_reg #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid),
`ifdef MUX_XFER_CNT_EN
        .xfer_cnt(xfer_cnt),
`endif
        .out_ready(out_ready)
    );

    mux_n_1_reg #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut3 (
        .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .sel(sel3), .mode(mode3), .out_data(out_data3),
        .out_ch(out_ch3), .out_valid(out_valid3),
`ifdef MUX_XFER_CNT_EN
        .xfer_cnt(xfer_cnt3),
`endif
        .out_ready(out_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 4'hF; mode = 1'b0; sel = 2'd2; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %0b want 0", out_valid); end
        tests++; if (out_data !== 8'h00) begin failed++; $display("FAIL reset_data got %h want 00", out_data); end
        tests++; if (out_ch !== 2'd0) begin failed++; $display("FAIL reset_ch got %0d want 0", out_ch); end
        tests++; if (in_ready !== 4'b0000) begin failed++; $display("FAIL reset_ready got %b want 0000", in_ready); end
        tests++; if (out_valid3 !== 1'b0) begin failed++; $display("FAIL reset_valid3 got %0b want 0", out_valid3); end
    endtask

    task automatic test_fixed();
        rst = 1'b0;
        #1;
        tests++; if (in_ready !== 4'b0100) begin failed++; $display("FAIL fixed_ready_pre got %b want 0100", in_ready); end
        tick();
        tests++; if (out_valid !== 1'b1) begin failed++; $display("FAIL fixed_valid got %0b want 1", out_valid); end
        tests++; if (out_data !== 8'hA5) begin failed++; $display("FAIL fixed_data got %h want a5", out_data); end
        tests++; if (out_ch !== 2'd2) begin failed++; $display("FAIL fixed_ch got %0d want 2", out_ch); end
        tests++; if (in_ready !== 4'b0100) begin failed++; $display("FAIL fixed_ready got %b want 0100", in_ready); end
        sel = 2'd1; in_valid = 4'b0000;
        #1;
        tests++; if (in_ready !== 4'b0010) begin failed++; $display("FAIL fixed_sel_change got %b want 0010", in_ready); end
        tick();
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL fixed_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_rr_fair();
        logic [1:0] exp_ch [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [7:0] exp_d  [6] = '{8'h10, 8'h21, 8'hA5, 8'h43, 8'h10, 8'h21};
        mode = 1'b1; in_valid = 4'hF;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++; if (out_ch !== exp_ch[i] || out_data !== exp_d[i] || out_valid !== 1'b1)
                begin failed++; $display("FAIL rr_fair[%0d] got ch=%0d d=%h v=%0b want ch=%0d d=%h v=1", i, out_ch, out_data, out_valid, exp_ch[i], exp_d[i]); end
        end
        in_valid = 4'h0;
        tick();
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL rr_fair_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_rr_skip();
        logic [1:0] exp_ch [3] = '{2'd1, 2'd3, 2'd1};
        rst = 1'b1;
        tick();
        rst = 1'b0; mode = 1'b1; in_valid = 4'b1010;
        #1;
        tests++; if (in_ready !== 4'b0010) begin failed++; $display("FAIL rr_skip_ready got %b want 0010", in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (out_ch !== exp_ch[i]) begin failed++; $display("FAIL rr_skip[%0d] got %0d want %0d", i, out_ch, exp_ch[i]); end
        end
        in_valid = 4'h0;
        tick();
    endtask

    task automatic test_backpressure();
        mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; out_ready = 1'b0;
        tick();
        tests++; if (out_valid !== 1'b1 || out_data !== 8'h21 || out_ch !== 2'd1)
            begin failed++; $display("FAIL bp_first got v=%0b d=%h ch=%0d want v=1 d=21 ch=1", out_valid, out_data, out_ch); end
        tests++; if (in_ready !== 4'b0000) begin failed++; $display("FAIL bp_ready got %b want 0000", in_ready); end
        in_data[15:8] = 8'h77;
        tick();
        tests++; if (out_valid !== 1'b1 || out_data !== 8'h21) begin failed++; $display("FAIL bp_hold got v=%0b d=%h want v=1 d=21", out_valid, out_data); end
        out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 4'b0010) begin failed++; $display("FAIL bp_release_ready got %b want 0010", in_ready); end
        tick();
        tests++; if (out_valid !== 1'b1 || out_data !== 8'h77) begin failed++; $display("FAIL bp_no_bubble got v=%0b d=%h want v=1 d=77", out_valid, out_data); end
        in_valid = 4'h0;
        tick();
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL bp_drain got %0b want 0", out_valid); end
        in_data[15:8] = 8'h21;
    endtask

    task automatic test_mid_reset();
        mode = 1'b0; sel = 2'd3; in_valid = 4'b1000; out_ready = 1'b0;
        tick();
        tests++; if (out_valid !== 1'b1 || out_data !== 8'h43) begin failed++; $display("FAIL mid_load got v=%0b d=%h want v=1 d=43", out_valid, out_data); end
        rst = 1'b1;
        tick();
        tests++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0)
            begin failed++; $display("FAIL mid_reset got v=%0b d=%h ch=%0d want 0 00 0", out_valid, out_data, out_ch); end
        tests++; if (in_ready !== 4'b0000) begin failed++; $display("FAIL mid_reset_ready got %b want 0000", in_ready); end
        rst = 1'b0; in_valid = 4'h0; out_ready = 1'b1;
        tick();
    endtask

    task automatic test_three_ch();
        logic [1:0] exp_ch [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
        logic [7:0] exp_d  [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hA0};
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
        #1;
        tests++; if (in_ready3 !== 3'b000) begin failed++; $display("FAIL oob_ready got %b want 000", in_ready3); end
        tick();
        tests++; if (out_valid3 !== 1'b0) begin failed++; $display("FAIL oob_valid got %0b want 0", out_valid3); end
`ifdef MUX_XFER_CNT_EN
        tests++; if (xfer_cnt3 !== 16'd0) begin failed++; $display("FAIL oob_cnt got %0d want 0", xfer_cnt3); end
`endif
        mode3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++; if (out_ch3 !== exp_ch[i] || out_data3 !== exp_d[i])
                begin failed++; $display("FAIL rr3_wrap[%0d] got ch=%0d d=%h want ch=%0d d=%h", i, out_ch3, out_data3, exp_ch[i], exp_d[i]); end
        end
        in_valid3 = 3'b000;
        tick();
`ifdef MUX_XFER_CNT_EN
        tests++; if (xfer_cnt3 !== 16'd4) begin failed++; $display("FAIL rr3_cnt got %0d want 4", xfer_cnt3); end
`endif
    endtask

`ifdef MUX_XFER_CNT_EN
    task automatic test_counter();
        rst = 1'b1;
        tick();
        rst = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
        #1;
        tests++; if (xfer_cnt !== 16'd0) begin failed++; $display("FAIL cnt_reset got %0d want 0", xfer_cnt); end
        repeat (65537) @(posedge clk);
        #1;
        in_valid = 4'h0;
        tests++; if (xfer_cnt !== 16'd1) begin failed++; $display("FAIL cnt_wrap got %0d want 1", xfer_cnt); end
        tick();
    endtask
`endif

    initial begin
        in_data   = {8'h43, 8'hA5, 8'h21, 8'h10};
        in_data3  = {8'hC2, 8'hB1, 8'hA0};
        in_valid3 = 3'b000; sel3 = 2'd0; mode3 = 1'b0;
        test_reset();
        test_fixed();
        test_rr_fair();
        test_rr_skip();
        test_backpressure();
        test_mid_reset();
        test_three_ch();
`ifdef MUX_XFER_CNT_EN
        test_counter();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
